seq_counter_16bit_en: RTL and testbench

//   Free-running 16-bit up-counter with synchronous reset and count enable.

---
 rtl/seq_counter_16bit_en_pkg.sv | 23 ++
 rtl/seq_counter_16bit_en_up_counter_en.sv | 30 +++
 rtl/seq_counter_16bit_en.sv | 52 +++++
 tb/tb_seq_counter_16bit_en.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seq_counter_16bit_en_pkg.sv
// -----------------------------------------------------------------------------
// seq_counter_16bit_en_pkg
//   Shared constants for the reference 16-bit counter user design.
//   IO_WIDTH   : width of the user I/O bus (io_in / io_out / io_oeb)
//   CNT_WIDTH  : counter width
//   RST_BIT    : io_in index of the synchronous, active-high reset
//   EN_BIT     : io_in index of the count enable
//   OUT_LSB    : io_out index of counter bit 0
//   OEB_MASK   : static active-low output enables (0 = pad driven)
// -----------------------------------------------------------------------------
package seq_counter_16bit_en_pkg;

  localparam int IO_WIDTH  = 28;
  localparam int CNT_WIDTH = 16;
  localparam int RST_BIT   = 0;
  localparam int EN_BIT    = 1;
  localparam int OUT_LSB   = 2;

  // Bits [17:2] carry the count and are driven (oeb = 0); every other pad
  // is left as an input (oeb = 1).
  localparam logic [IO_WIDTH-1:0] OEB_MASK = 28'hFFC0003;

endpackage : seq_counter_16bit_en_pkg

// File: rtl/seq_counter_16bit_en_up_counter_en.sv
// -----------------------------------------------------------------------------
// up_counter_en
//   Parameterised up-counter with synchronous active-high reset and enable.
//   Reset has priority over enable; the count wraps modulo 2^WIDTH with no
//   carry out.
// Ports
//   clk : rising-edge clock
//   rst : synchronous reset, active high (clears q)
//   en  : count enable (q increments when high and rst is low)
//   q   : counter value, straight from the flops
// -----------------------------------------------------------------------------
module up_counter_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      // Natural overflow of the WIDTH-bit add gives the modulo wrap.
      q <= q + WIDTH'(1);
    end
  end

endmodule : up_counter_en

// File: rtl/seq_counter_16bit_en.sv
// -----------------------------------------------------------------------------
// seq_counter_16bit_en
//   Reference user design for the eFPGA fabric: a free-running 16-bit
//   up-counter controlled from, and reported on, the 28-bit user I/O bus.
// Ports
//   clk    : rising-edge clock, sole clock
//   io_in  : io_in[RST_BIT] = synchronous active-high reset,
//            io_in[EN_BIT]  = count enable, all other bits ignored
//   io_out : count on [OUT_LSB +: CNT_WIDTH], every other bit 0
//   io_oeb : constant active-low output enables (OEB_MASK)
// There is no combinational path from io_in to either output: io_out is
// taken straight from the counter flops and io_oeb is a constant.
// -----------------------------------------------------------------------------
module seq_counter_16bit_en
  import seq_counter_16bit_en_pkg::*;
(
  input  logic                clk,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb
);

  logic                 rst;
  logic                 en;
  logic [CNT_WIDTH-1:0] cnt;

  assign rst = io_in[RST_BIT];
  assign en  = io_in[EN_BIT];

  // The remaining input pads are deliberately ignored; fold them into one
  // named sink so the intent is explicit.
  logic unused_io_in;
  assign unused_io_in = ^io_in[IO_WIDTH-1:EN_BIT+1];

  up_counter_en #(
    .WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (cnt)
  );

  always_comb begin
    io_out                        = '0;
    io_out[OUT_LSB +: CNT_WIDTH]  = cnt;
  end

  // Static from time zero; independent of reset.
  assign io_oeb = OEB_MASK;

endmodule : seq_counter_16bit_en

// File: tb/tb_seq_counter_16bit_en.sv
`timescale 1ns/1ps
module tb_seq_counter_16bit_en;

  localparam logic [27:0] EXP_OE = 28'h003FFFC;

  // ---------------- clock / reset block ----------------
  logic        clk;
  logic [27:0] io_in;
  logic [27:0] io_out;
  logic [27:0] io_oeb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_counter_16bit_en dut (
    .clk    (clk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [27:0] exp_q[$];

  // Reference model: the count as a plain integer, advanced by the rules
  // reset -> 0, enable -> +1 mod 65536, otherwise hold.
  int model_cnt = 0;

  function automatic logic [27:0] bus_of(input int c);
    return 28'((c % 65536) * 4);
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs, let the edge happen, update model, compare at
  // the following negedge against the head of the expected queue.
  task automatic do_cycle(input logic [27:0] v, input string name);
    logic [27:0] e;
    io_in = v;
    @(posedge clk);
    if (v[0])      model_cnt = 0;
    else if (v[1]) model_cnt = (model_cnt + 1) % 65536;
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, io_out, e);
    check({name, "_oe"}, ~io_oeb, EXP_OE);
  endtask

  task automatic apply_exp(input logic [27:0] v, input int exp_cnt, input string name);
    exp_q.push_back(bus_of(exp_cnt));
    do_cycle(v, name);
  endtask

  task automatic apply_model(input logic [27:0] v, input string name);
    int nxt;
    if (v[0])      nxt = 0;
    else if (v[1]) nxt = (model_cnt + 1) % 65536;
    else           nxt = model_cnt;
    exp_q.push_back(bus_of(nxt));
    do_cycle(v, name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [27:0] in;
    int          exp_cnt;
  } vec_t;

  vec_t tv[105];

  // Watchdog: the whole run is clock-bounded, this only guards a stall.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    io_in = 28'h0;

    // Output enables must be valid before any edge.
    #1;
    check("oe_time0", ~io_oeb, EXP_OE);
    @(negedge clk);

    // Table: 5 cycles reset+enable, then 100 cycles enable only.
    for (int i = 0; i < 5; i++) begin
      tv[i].in = 28'h3; tv[i].exp_cnt = 0;
    end
    for (int k = 1; k <= 100; k++) begin
      tv[4 + k].in = 28'h2; tv[4 + k].exp_cnt = k;
    end
    for (int i = 0; i < 105; i++) apply_exp(tv[i].in, tv[i].exp_cnt, "table");

    // Hold: reset, count to 10, then 20 cycles with enable low.
    apply_exp(28'h1, 0, "hold_rst");
    for (int k = 1; k <= 10; k++) apply_exp(28'h2, k, "hold_cnt");
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(28'h28);
      do_cycle(28'h0, "hold");
    end

    // Reset mid-count with enable still high, then counting resumes.
    apply_exp(28'h1, 0, "mid_rst0");
    for (int k = 0; k < 50; k++) apply_model(28'h2, "mid_up");
    apply_exp(28'h3, 0, "mid_rst");
    apply_exp(28'h2, 1, "mid_after1");
    apply_exp(28'h2, 2, "mid_after2");
    apply_exp(28'h2, 3, "mid_after3");

    // Random upper bits with enable high: count and oeb unaffected.
    for (int k = 0; k < 200; k++) begin
      logic [27:0] v;
      v = {$urandom_range(0, 32'h03FF_FFFF) & 26'h3FF_FFFF, 2'b10};
      apply_model(v, "noise");
    end

    // Fully random controls against the model.
    for (int k = 0; k < 300; k++) begin
      logic [27:0] v;
      v = 28'($urandom);
      v[0] = ($urandom_range(0, 7) == 0);
      apply_model(v, "random");
    end

    // Wrap: count up to 0xFFFE, then FFFF, 0000, 0001.
    apply_exp(28'h1, 0, "wrap_rst");
    for (int k = 0; k < 65534; k++) apply_model(28'h2, "wrap_run");
    apply_exp(28'h2, 16'hFFFF, "wrap_ffff");
    apply_exp(28'h2, 0, "wrap_0000");
    apply_exp(28'h2, 1, "wrap_0001");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_seq_counter_16bit_en
